// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on operand and result sides.
//
// Executes single-cycle ops (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU) in one cycle
// and iterative ops (MUL, DIVU, REMU) in WIDTH iterations, one bit per cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands and opcode valid
//   in_ready     block can accept a new op (high only in IDLE)
//   operand_a    first operand
//   operand_b    second operand
//   alu_control  4-bit opcode
//   out_valid    result valid (high in DONE until out_ready)
//   out_ready    consumer accepts result
//   result       registered result
//   zero         registered (result == 0)
//   busy         high while an iterative op is in progress
//   carry        (SEQ_ALU_FLAGS_EN only) ADD carry-out / SUB no-borrow
//   overflow     (SEQ_ALU_FLAGS_EN only) signed overflow of ADD/SUB
//
// Optional feature macro: SEQ_ALU_FLAGS_EN adds the carry/overflow outputs.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic             carry,
    output logic             overflow
`endif
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             zero_q, zero_d;
    logic             accept, iter_op, last;
    logic [WIDTH-1:0] add_s, sub_s, simple_res, mul_acc, div_rem;
    logic [WIDTH:0]   rem_sh;
    logic             ge;

    assign accept  = in_valid && (state_q == IDLE);
    assign iter_op = alu_control inside {OP_MUL, OP_DIVU, OP_REMU};
    assign last    = cnt_q == CNT_W'(WIDTH - 1);
    assign add_s   = operand_a + operand_b;
    assign sub_s   = operand_a - operand_b;

    // Shift-add step: a_q is the left-shifting multiplicand, b_q the right-shifting multiplier.
    assign mul_acc = acc_q + (b_q[0] ? a_q : '0);

    // Restoring-division step: acc_q is the partial remainder, a_q shifts the dividend
    // out MSB-first while quotient bits shift in at the bottom. The remainder is always
    // below the divisor, so the WIDTH-bit subtraction is exact. With a zero divisor every
    // quotient bit is 1 and the dividend passes through as the remainder.
    assign rem_sh  = {acc_q, a_q[WIDTH-1]};
    assign ge      = rem_sh >= {1'b0, b_q};
    assign div_rem = ge ? rem_sh[WIDTH-1:0] - b_q : rem_sh[WIDTH-1:0];

    always_comb begin
        simple_res = '0;
        case (alu_control)
            4'b0000: simple_res = add_s;
            4'b0001: simple_res = sub_s;
            4'b0010: simple_res = operand_a & operand_b;
            4'b0011: simple_res = operand_a | operand_b;
            4'b0100: simple_res = operand_a ^ operand_b;
            4'b0101: simple_res = ~(operand_a | operand_b);
            4'b0110: simple_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            4'b0111: simple_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            default: simple_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (accept && iter_op) begin
                    a_d     = operand_a;
                    b_d     = operand_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    op_d    = alu_control;
                    state_d = BUSY;
                end else if (accept) begin
                    result_d = simple_res;
                    zero_d   = simple_res == '0;
                    state_d  = DONE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                end else begin
                    acc_d = div_rem;
                    a_d   = {a_q[WIDTH-2:0], ge};
                end
                if (last) begin
                    result_d = (op_q == OP_MUL) ? mul_acc : (op_q == OP_DIVU) ? a_d : div_rem;
                    zero_d   = result_d == '0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q == BUSY;
    assign result    = result_q;
    assign zero      = zero_q;

`ifdef SEQ_ALU_FLAGS_EN
    logic carry_q, carry_d, ovf_q, ovf_d;
    logic sa, sb;

    assign sa = operand_a[WIDTH-1];
    assign sb = operand_b[WIDTH-1];

    // Flags are captured on every accept; iterative and logic ops clear them.
    always_comb begin
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (accept) begin
            carry_d = (alu_control == OP_ADD) ? ((sa & sb) | ((sa | sb) & ~add_s[WIDTH-1])) :
                      (alu_control == OP_SUB) ? (operand_a >= operand_b) : 1'b0;
            ovf_d   = (alu_control == OP_ADD) ? ((sa == sb) && (add_s[WIDTH-1] != sa)) :
                      (alu_control == OP_SUB) ? ((sa != sb) && (sub_s[WIDTH-1] != sa)) : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign carry    = carry_q;
    assign overflow = ovf_q;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand_a, operand_b;
    logic [3:0]   alu_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
`ifdef SEQ_ALU_FLAGS_EN
    logic         carry, overflow;
`endif

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .alu_control(alu_control),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero),
        .busy(busy)
`ifdef SEQ_ALU_FLAGS_EN
        ,
        .carry(carry),
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd7:    return (a < b) ? W'(1) : W'(0);
            4'd8:    begin p = 64'(a) * 64'(b); return W'(p); end
            4'd9:    return (b == 0) ? {W{1'b1}} : a / b;
            4'd10:   return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    // Drives one op, waits for out_valid (bounded), records latency, busy cycles and
    // in_ready-high cycles seen while waiting, then consumes the handshake edge.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic z, output int lat,
                         output int bcnt, output int rdy_hi);
        @(negedge clk);
        in_valid = 1'b1; alu_control = op; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom; alu_control = 4'($urandom_range(0, 15));
        lat = 1; bcnt = 0; rdy_hi = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bcnt++;
            if (in_ready) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        logic [W-1:0] r; logic z; int lat, bc, rh, stale;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        operand_a = '0; operand_b = '0; alu_control = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (result !== '0) begin errors++; $display("FAIL rst_result got %h exp 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rst_zero got %b exp 1", zero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        @(negedge clk); rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        // abort a MUL mid-BUSY with a fresh result in flight
        do_op(4'd0, 32'd7, 32'd8, r, z, lat, bc, rh);
        @(negedge clk);
        in_valid = 1'b1; alu_control = 4'd8; operand_a = 32'd12345; operand_b = 32'd6789;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midbusy_out_valid got %b exp 0", out_valid); end
        checks++; if (result !== '0) begin errors++; $display("FAIL midbusy_result got %h exp 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL midbusy_zero got %b exp 1", zero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midbusy_busy got %b exp 0", busy); end
        @(negedge clk); rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midbusy_in_ready got %b exp 1", in_ready); end
        stale = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) stale++; end
        checks++; if (stale != 0) begin errors++; $display("FAIL midbusy_stale got %0d exp 0", stale); end
    endtask

    task automatic test_simple;
        logic [3:0] ops [4] = '{4'd0, 4'd6, 4'd7, 4'd5};
        logic [W-1:0] as [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        logic [W-1:0] bs [4] = '{32'h1, 32'h1, 32'h1, 32'h0};
        logic [W-1:0] exs [4] = '{32'h0, 32'h1, 32'h0, 32'hFFFFFFFF};
        logic [W-1:0] r, a, b, e; logic z; logic [3:0] op; int lat, bc, rh;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], r, z, lat, bc, rh);
            checks++; if (r !== exs[i]) begin errors++; $display("FAIL simple_dir%0d result got %h exp %h", i, r, exs[i]); end
            checks++; if (z !== (exs[i] == 0)) begin errors++; $display("FAIL simple_dir%0d zero got %b exp %b", i, z, exs[i] == 0); end
            checks++; if (lat != 1) begin errors++; $display("FAIL simple_dir%0d latency got %0d exp 1", i, lat); end
        end
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 12));
            if (op >= 4'd8 && op <= 4'd10) op = op + 4'd5;
            a = $urandom; b = (i % 4 == 0) ? a : $urandom;
            e = model(op, a, b);
            do_op(op, a, b, r, z, lat, bc, rh);
            checks++; if (r !== e || z !== (e == 0) || lat != 1) begin
                errors++; $display("FAIL simple_rand op %0d a %h b %h got %h/%b/%0d exp %h/%b/1", op, a, b, r, z, lat, e, e == 0);
            end
        end
    endtask

    task automatic test_iterative;
        logic [3:0] ops [5] = '{4'd8, 4'd9, 4'd10, 4'd9, 4'd10};
        logic [W-1:0] as [5] = '{32'd12345, 32'd100, 32'd100, 32'd5, 32'd5};
        logic [W-1:0] bs [5] = '{32'd6789, 32'd7, 32'd7, 32'd0, 32'd0};
        logic [W-1:0] exs [5] = '{32'd83810205, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5};
        logic [W-1:0] r, a, b, e; logic z; logic [3:0] op; int lat, bc, rh;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], r, z, lat, bc, rh);
            checks++; if (r !== exs[i]) begin errors++; $display("FAIL iter_dir%0d result got %h exp %h", i, r, exs[i]); end
            checks++; if (lat != W + 1) begin errors++; $display("FAIL iter_dir%0d latency got %0d exp %0d", i, lat, W + 1); end
            checks++; if (bc != W) begin errors++; $display("FAIL iter_dir%0d busy_cycles got %0d exp %0d", i, bc, W); end
            checks++; if (rh != 0) begin errors++; $display("FAIL iter_dir%0d in_ready_high got %0d exp 0", i, rh); end
        end
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(8, 10));
            a = $urandom;
            b = (i % 6 == 0) ? '0 : (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
            if (i % 5 == 0) a = '0;
            e = model(op, a, b);
            do_op(op, a, b, r, z, lat, bc, rh);
            checks++; if (r !== e || z !== (e == 0) || lat != W + 1) begin
                errors++; $display("FAIL iter_rand op %0d a %h b %h got %h/%b/%0d exp %h/%b/%0d", op, a, b, r, z, lat, e, e == 0, W + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; alu_control = 4'd1; operand_a = 32'd3; operand_b = 32'd5;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 32'hFFFFFFFE || in_ready !== 1'b0) bad++;
            in_valid = $urandom_range(0, 1); alu_control = 4'd0; operand_a = $urandom; operand_b = $urandom;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad); end
        in_valid = 1'b1; alu_control = 4'd0; operand_a = 32'd40; operand_b = 32'd2;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release got out_valid %b in_ready %b exp 0 1", out_valid, in_ready); end
        checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL backpressure_no_accept got %h exp fffffffe", result); end
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'd42) begin errors++; $display("FAIL backpressure_next got %b/%h exp 1/0000002a", out_valid, result); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a, b, e; logic [3:0] op; int bad = 0;
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            e = model(op, a, b);
            if (in_ready !== 1'b1) bad++;
            in_valid = 1'b1; alu_control = op; operand_a = a; operand_b = b;
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== e || in_ready !== 1'b0) bad++;
            alu_control = 4'($urandom_range(0, 7)); operand_a = $urandom; operand_b = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL back_to_back got %0d bad cycles exp 0", bad); end
    endtask

`ifdef SEQ_ALU_FLAGS_EN
    task automatic test_flags;
        logic [W-1:0] r, a, b; logic z, ec, eo; logic [3:0] op; int lat, bc, rh;
        longint sr;
        for (int i = 0; i < 30; i++) begin
            op = (i < 20) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 10));
            a = (i == 0) ? 32'h7FFFFFFF : (i == 1) ? 32'h0 : $urandom;
            b = (i == 0) ? 32'h1 : (i == 1) ? 32'h1 : $urandom;
            if (i == 0) op = 4'd0;
            if (i == 1) op = 4'd1;
            sr = (op == 4'd0) ? longint'($signed(a)) + longint'($signed(b)) : longint'($signed(a)) - longint'($signed(b));
            ec = (op == 4'd0) ? (64'(a) + 64'(b) > 64'hFFFFFFFF) : (op == 4'd1) ? (a >= b) : 1'b0;
            eo = (op <= 4'd1) ? (sr > 64'sh7FFFFFFF || sr < -64'sh80000000) : 1'b0;
            do_op(op, a, b, r, z, lat, bc, rh);
            checks++; if (carry !== ec || overflow !== eo || r !== model(op, a, b)) begin
                errors++; $display("FAIL flags op %0d a %h b %h got c%b v%b %h exp c%b v%b %h", op, a, b, carry, overflow, r, ec, eo, model(op, a, b));
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_simple;
        test_iterative;
        test_backpressure;
        test_back_to_back;
`ifdef SEQ_ALU_FLAGS_EN
        test_flags;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
